// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter that frames 16-bit words into 3-byte packets
// (header, low byte, high byte) for an 8N1 UART transmitter.
module uart_tx_arbiter #(
  parameter logic [7:0] HDR_BASE = 8'hA0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [15:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_data,
  output logic        req1_ready,
  output logic [7:0]  tx_byte,
  output logic        tx_send,
  input  logic        tx_done,
  output logic        busy,
  output logic [15:0] frames_sent
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  // Byte to transmit at a given frame position; header LSB carries the source ID.
  function automatic logic [7:0] frame_byte(input logic [1:0]  idx,
                                            input logic        src,
                                            input logic [15:0] data);
    case (idx)
      2'd0:    frame_byte = {HDR_BASE[7:1], src};
      2'd1:    frame_byte = data[7:0];
      2'd2:    frame_byte = data[15:8];
      default: frame_byte = 8'h00;
    endcase
  endfunction

  state_t      state_r, state_s;
  logic [1:0]  idx_r, idx_s;
  logic [15:0] data_r, data_s;
  logic        src_r, src_s;
  logic        last_r, last_s;
  logic [15:0] frames_r, frames_s;
  logic [7:0]  tx_byte_r, tx_byte_s;
  logic        tx_send_r, tx_send_s;
  logic        busy_r, busy_s;
  logic        grant_s;
  logic        accept_s;
  logic [1:0]  idx_inc_s;

  // Round-robin grant: on contention, favour the requester not served last.
  always_comb begin
    grant_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_s = ~last_r;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  assign req0_ready = !rst && (state_r == IDLE) && req0_valid && !grant_s;
  assign req1_ready = !rst && (state_r == IDLE) && req1_valid &&  grant_s;
  assign accept_s   = req0_ready || req1_ready;
  assign idx_inc_s  = idx_r + 2'd1;

  // Frame sequencer: next-state and next-output computation.
  always_comb begin
    state_s   = state_r;
    idx_s     = idx_r;
    data_s    = data_r;
    src_s     = src_r;
    last_s    = last_r;
    frames_s  = frames_r;
    tx_byte_s = tx_byte_r;
    tx_send_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          data_s    = grant_s ? req1_data : req0_data;
          src_s     = grant_s;
          last_s    = grant_s;
          idx_s     = 2'd0;
          state_s   = SEND;
          tx_send_s = 1'b1;
          tx_byte_s = frame_byte(2'd0, grant_s, 16'h0000);
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        // tx_done is deliberately not looked at here.
        state_s = WAIT;
      end
      WAIT: begin
        if (tx_done) begin
          if (idx_r == 2'd2) begin
            frames_s = frames_r + 16'd1;
            idx_s    = 2'd0;
            state_s  = IDLE;
          end else begin
            idx_s     = idx_inc_s;
            state_s   = SEND;
            tx_send_s = 1'b1;
            tx_byte_s = frame_byte(idx_inc_s, src_r, data_r);
          end
        end else begin
          state_s = WAIT;
        end
      end
      default: begin
        state_s = IDLE;
        idx_s   = 2'd0;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      idx_r     <= 2'd0;
      data_r    <= 16'h0000;
      src_r     <= 1'b0;
      last_r    <= 1'b1;
      frames_r  <= 16'h0000;
      tx_byte_r <= 8'h00;
      tx_send_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      idx_r     <= idx_s;
      data_r    <= data_s;
      src_r     <= src_s;
      last_r    <= last_s;
      frames_r  <= frames_s;
      tx_byte_r <= tx_byte_s;
      tx_send_r <= tx_send_s;
      busy_r    <= busy_s;
    end
  end

  assign tx_byte     = tx_byte_r;
  assign tx_send     = tx_send_r;
  assign busy        = busy_r;
  assign frames_sent = frames_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected bytes are queued by the
// stimulus and popped by an independent monitor on every tx_send.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic [7:0]  tx_byte;
  logic        tx_send;
  logic        tx_done;
  logic        busy;
  logic [15:0] frames_sent;

  int          vectors;
  int          miscompares;
  logic [7:0]  exp_q[$];
  logic [15:0] exp_frames;
  logic        prev_send;

  uart_tx_arbiter #(.HDR_BASE(8'hA0)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .tx_byte    (tx_byte),
    .tx_send    (tx_send),
    .tx_done    (tx_done),
    .busy       (busy),
    .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every send strobe must match the head of the scoreboard queue.
  always @(negedge clk) begin
    if (!rst && tx_send === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_send: got byte %h with empty scoreboard at %0t", tx_byte, $time);
      end else begin
        check("tx_byte", {24'h0, tx_byte}, {24'h0, exp_q.pop_front()});
      end
      check("send_one_cycle", {31'h0, prev_send}, 32'h0);
    end
    prev_send <= (tx_send === 1'b1) && !rst;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic src, input logic [15:0] d);
    exp_q.push_back(src ? 8'hA1 : 8'hA0);
    exp_q.push_back(d[7:0]);
    exp_q.push_back(d[15:8]);
  endtask

  // Precondition: current cycle is a SEND cycle (tx_send high).
  task automatic serve_byte(input int delay, input logic last);
    logic [7:0] b;
    b = tx_byte;
    tick;
    for (int i = 0; i < delay; i++) begin
      check("hold_send", {31'h0, tx_send}, 32'h0);
      check("hold_byte", {24'h0, tx_byte}, {24'h0, b});
      tick;
    end
    tx_done = 1'b1;
    tick;
    tx_done = 1'b0;
    check("send_after_done", {31'h0, tx_send}, last ? 32'h0 : 32'h1);
    if (last) begin
      exp_frames++;
      check("frames_sent", {16'h0, frames_sent}, {16'h0, exp_frames});
      check("busy_after_frame", {31'h0, busy}, 32'h0);
    end else begin
      check("busy_mid_frame", {31'h0, busy}, 32'h1);
    end
  endtask

  task automatic start_frame(input logic src, input logic [15:0] d);
    if (src) begin
      req1_valid = 1'b1;
      req1_data  = d;
    end else begin
      req0_valid = 1'b1;
      req0_data  = d;
    end
    #2;
    check("ready_grant", {30'h0, req1_ready, req0_ready}, src ? 32'h2 : 32'h1);
    push_frame(src, d);
    tick;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("accept_latency", {31'h0, tx_send}, 32'h1);
    check("busy_on_send", {31'h0, busy}, 32'h1);
  endtask

  task automatic run_frame(input logic src, input logic [15:0] d, input int delay);
    start_frame(src, d);
    serve_byte(delay, 1'b0);
    serve_byte(delay, 1'b0);
    serve_byte(delay, 1'b1);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    exp_q.delete();
    exp_frames = 16'h0000;
  endtask

  initial begin
    clk         = 1'b0;
    rst         = 1'b1;
    req0_valid  = 1'b0;
    req1_valid  = 1'b0;
    req0_data   = 16'h0000;
    req1_data   = 16'h0000;
    tx_done     = 1'b0;
    vectors     = 0;
    miscompares = 0;
    exp_frames  = 16'h0000;
    prev_send   = 1'b0;

    // Reset state, with a valid requester held during reset.
    req0_valid = 1'b1;
    tick;
    tick;
    check("ready_in_reset", {30'h0, req1_ready, req0_ready}, 32'h0);
    check("reset_tx_send", {31'h0, tx_send}, 32'h0);
    check("reset_tx_byte", {24'h0, tx_byte}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_frames", {16'h0, frames_sent}, 32'h0);
    req0_valid = 1'b0;
    rst = 1'b0;
    tick;

    // Single word from requester 0.
    run_frame(1'b0, 16'h1234, 0);

    // Contention: both valid throughout, grants must alternate from requester 0.
    do_reset();
    req0_valid = 1'b1;
    req0_data  = 16'hAAAA;
    req1_valid = 1'b1;
    req1_data  = 16'h5555;
    for (int k = 0; k < 4; k++) begin
      logic s;
      s = k[0];
      #2;
      check("contend_ready", {30'h0, req1_ready, req0_ready}, s ? 32'h2 : 32'h1);
      push_frame(s, s ? 16'h5555 : 16'hAAAA);
      tick;
      check("contend_send", {31'h0, tx_send}, 32'h1);
      check("ready_while_busy", {30'h0, req1_ready, req0_ready}, 32'h0);
      serve_byte(0, 1'b0);
      serve_byte(0, 1'b0);
      serve_byte(0, 1'b1);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick;

    // Slow transmitter: tx_done held off 20 cycles per byte.
    run_frame(1'b1, 16'hBEEF, 20);

    // Spurious tx_done in IDLE and in the SEND cycle.
    tx_done = 1'b1;
    tick;
    tx_done = 1'b0;
    check("spur_idle_busy", {31'h0, busy}, 32'h0);
    check("spur_idle_send", {31'h0, tx_send}, 32'h0);
    check("spur_idle_frames", {16'h0, frames_sent}, {16'h0, exp_frames});
    tick;
    start_frame(1'b0, 16'hC3D4);
    tx_done = 1'b1;
    tick;
    tx_done = 1'b0;
    check("spur_send_nosend", {31'h0, tx_send}, 32'h0);
    check("spur_send_byte", {24'h0, tx_byte}, 32'hA0);
    tick;
    check("spur_send_wait", {31'h0, tx_send}, 32'h0);
    tx_done = 1'b1;
    tick;
    tx_done = 1'b0;
    check("spur_resume", {31'h0, tx_send}, 32'h1);
    serve_byte(0, 1'b0);
    serve_byte(0, 1'b1);

    // Reset mid-frame after the second byte is sent, with a late tx_done.
    start_frame(1'b0, 16'h7788);
    serve_byte(0, 1'b0);
    tick;
    rst     = 1'b1;
    tx_done = 1'b1;
    tick;
    check("midrst_send", {31'h0, tx_send}, 32'h0);
    check("midrst_byte", {24'h0, tx_byte}, 32'h0);
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_frames", {16'h0, frames_sent}, 32'h0);
    rst = 1'b0;
    tick;
    tx_done = 1'b0;
    check("late_done_send", {31'h0, tx_send}, 32'h0);
    check("late_done_busy", {31'h0, busy}, 32'h0);
    check("abandoned_bytes", exp_q.size(), 32'h1);
    exp_q.delete();
    exp_frames = 16'h0000;
    tick;
    run_frame(1'b1, 16'h0102, 0);

    // Counter wrap.
    force dut.frames_r = 16'hFFFF;
    #1;
    release dut.frames_r;
    check("wrap_preload", {16'h0, frames_sent}, 32'hFFFF);
    exp_frames = 16'hFFFF;
    run_frame(1'b0, 16'h0F0F, 0);
    check("wrap_zero", {16'h0, frames_sent}, 32'h0);

    tick;
    tick;
    check("scoreboard_empty", exp_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
